// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM time-slot arbiter.
package sram_arb_pkg;

  // Who owns the slot currently on the bus
  typedef enum logic [1:0] {VIDEO, CPU, AUX, IDLE} owner_t;

  // phase[0] value of the address and data cycles of a slot
  localparam logic ADDR_PH = 1'b0;
  localparam logic DATA_PH = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/sram_slot_timer.sv
// 8-phase ring counter for the SRAM bus, plus the video slot markers.
// phase_nxt is exposed so the arbiter can act on the edge that enters
// each phase. The first edge after reset re-enters phase 0 so that slot 0
// is started cleanly.
module sram_slot_timer
  import sram_arb_pkg::*;
(
  input  logic       clk24,
  input  logic       reset,
  input  logic       retrace,
  output logic [2:0] phase,
  output logic [2:0] phase_nxt,
  output logic       video_slice,
  output logic       pipe_ab
);

  logic run;

  assign phase_nxt = run ? phase + 3'd1 : 3'd0;

  // Advance the ring; video ownership is only re-evaluated on address edges
  always_ff @(posedge clk24) begin
    if (reset) begin
      run         <= 1'b0;
      phase       <= 3'd0;
      video_slice <= 1'b0;
      pipe_ab     <= 1'b0;
    end else begin
      run     <= 1'b1;
      phase   <= phase_nxt;
      pipe_ab <= phase_nxt[2];
      if (phase_nxt[0] == ADDR_PH)
        video_slice <= !phase_nxt[1] && !retrace;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shared 8-bit SRAM slot scheduler: video in slots 0/2, CPU and aux in 1/3.
// Optional feature macro: SRAM_ARB_AUX_EN enables the aux port, retrace
// donation of video slots and the aux starvation counter.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic        retrace,
  input  logic [15:0] vid_addr,
  output logic        video_slice,
  output logic        pipe_ab,
  output logic [2:0]  phase,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic [7:0]  aux_rdata,
  input  logic [7:0]  SRAM_DQ,
  output logic [15:0] SRAM_ADDR,
  output logic [7:0]  SRAM_WDATA,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  logic [2:0] phase_nxt;
  owner_t     grant, owner;
  logic       acc_we;
  logic       aux_ok, starved;
  logic       aux_ack_q;
  logic [7:0] aux_rdata_q;
  logic       addr_edge, req_slot;

  sram_slot_timer u_timer (
    .clk24       (clk24),
    .reset       (reset),
    .retrace     (retrace),
    .phase       (phase),
    .phase_nxt   (phase_nxt),
    .video_slice (video_slice),
    .pipe_ab     (pipe_ab)
  );

  assign addr_edge = (phase_nxt[0] == ADDR_PH);
  assign req_slot  = phase_nxt[1];   // slots 1 and 3

`ifdef SRAM_ARB_AUX_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign aux_ok    = aux_req;
  assign starved   = (starve_cnt == LIMIT);
  assign aux_ack   = aux_ack_q;
  assign aux_rdata = aux_rdata_q;

  // Count CPU wins while aux waits; any aux win or idle aux clears it
  always_ff @(posedge clk24) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (!aux_req)
      starve_cnt <= 4'd0;
    else if (addr_edge && grant == AUX)
      starve_cnt <= 4'd0;
    else if (addr_edge && grant == CPU && !starved)
      starve_cnt <= starve_cnt + 4'd1;
  end
`else
  logic unused_aux;

  assign aux_ok     = 1'b0;
  assign starved    = 1'b0;
  assign aux_ack    = 1'b0;
  assign aux_rdata  = 8'h00;
  assign unused_aux = ^{aux_req, aux_ack_q, aux_rdata_q, 4'(STARVE_LIMIT)};
`endif

  // Owner of the slot that starts on the coming address edge
  always_comb begin
    grant = IDLE;
    if (!req_slot)
      grant = retrace ? (aux_ok ? AUX : IDLE) : VIDEO;
    else if (cpu_req && !(starved && aux_ok))
      grant = CPU;
    else if (aux_ok)
      grant = AUX;
  end

  // Address edge: retire the finishing slot (ack + read data), launch the next.
  // Data edge: pulse the write strobe for requester writes.
  always_ff @(posedge clk24) begin
    if (reset) begin
      owner       <= IDLE;
      acc_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'h00;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= 8'h00;
      SRAM_ADDR   <= 16'h0000;
      SRAM_WDATA  <= 8'h00;
      SRAM_WE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
    end else begin
      cpu_ack   <= 1'b0;
      aux_ack_q <= 1'b0;
      if (addr_edge) begin
        if (owner == CPU) begin
          cpu_ack <= 1'b1;
          if (!acc_we) cpu_rdata <= SRAM_DQ;
        end
        if (owner == AUX) begin
          aux_ack_q <= 1'b1;
          if (!acc_we) aux_rdata_q <= SRAM_DQ;
        end
        SRAM_WE_N <= 1'b1;
        owner     <= grant;
        case (grant)
          VIDEO: begin
            SRAM_ADDR <= vid_addr;
            SRAM_OE_N <= 1'b0;
            acc_we    <= 1'b0;
          end
          CPU: begin
            SRAM_ADDR  <= cpu_addr;
            SRAM_WDATA <= cpu_wdata;
            SRAM_OE_N  <= cpu_we;
            acc_we     <= cpu_we;
          end
          AUX: begin
            SRAM_ADDR  <= aux_addr;
            SRAM_WDATA <= aux_wdata;
            SRAM_OE_N  <= aux_we;
            acc_we     <= aux_we;
          end
          default: begin
            SRAM_OE_N <= 1'b1;
            acc_we    <= 1'b0;
          end
        endcase
      end else if (phase_nxt[0] == DATA_PH) begin
        SRAM_WE_N <= !((owner == CPU || owner == AUX) && acc_we);
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a cycle table from reset through video,
// CPU write, CPU read and retrace, then hand sequences for reset abort and
// the aux port (enabled or disabled build).
module tb_sram_arbiter;
  logic        clk24 = 1'b0;
  logic        reset, retrace;
  logic [15:0] vid_addr;
  logic        video_slice, pipe_ab;
  logic [2:0]  phase;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        aux_req, aux_we, aux_ack;
  logic [15:0] aux_addr;
  logic [7:0]  aux_wdata, aux_rdata;
  logic [7:0]  SRAM_DQ;
  logic [15:0] SRAM_ADDR;
  logic [7:0]  SRAM_WDATA;
  logic        SRAM_WE_N, SRAM_OE_N;

  int checks = 0;
  int errors = 0;

  always #5 clk24 = ~clk24;

  sram_arbiter dut (
    .clk24(clk24), .reset(reset), .retrace(retrace), .vid_addr(vid_addr),
    .video_slice(video_slice), .pipe_ab(pipe_ab), .phase(phase),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  typedef struct {
    logic        rt, rq, we;
    logic [15:0] a;
    logic [7:0]  wd, dq;
    logic [2:0]  ph;
    logic        vs, pab;
    logic [15:0] sa;
    logic [7:0]  swd;
    logic        wen, oen, ack;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic rt, rq, we, input logic [15:0] a,
                              input logic [7:0] wd, dq, input logic [2:0] ph,
                              input logic vs, pab, input logic [15:0] sa,
                              input logic [7:0] swd, input logic wen, oen, ack,
                              input logic [7:0] rd);
    vec_t v;
    v.rt = rt; v.rq = rq; v.we = we; v.a = a; v.wd = wd; v.dq = dq;
    v.ph = ph; v.vs = vs; v.pab = pab; v.sa = sa; v.swd = swd;
    v.wen = wen; v.oen = oen; v.ack = ack; v.rd = rd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk24);
    @(negedge clk24);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    while (phase !== p && n < 16) begin
      step();
      n++;
    end
    chk("wait_phase", 64'(phase), 64'(p));
  endtask

  initial begin
    int acks, cnt, bad, n, both;
    logic [9:0] seq;

    //            rt rq we addr      wd     dq     ph   vs pab sa        swd    wen oen ack rd
    tbl[0]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd0, 1, 0, 16'hA000, 8'h00, 1, 0, 0, 8'h00);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd1, 1, 0, 16'hA000, 8'h00, 1, 0, 0, 8'h00);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd2, 0, 0, 16'hA000, 8'h00, 1, 1, 0, 8'h00);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd3, 0, 0, 16'hA000, 8'h00, 1, 1, 0, 8'h00);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd4, 1, 1, 16'hA004, 8'h00, 1, 0, 0, 8'h00);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd5, 1, 1, 16'hA004, 8'h00, 1, 0, 0, 8'h00);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd6, 0, 1, 16'hA004, 8'h00, 1, 1, 0, 8'h00);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd7, 0, 1, 16'hA004, 8'h00, 1, 1, 0, 8'h00);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd0, 1, 0, 16'hA008, 8'h00, 1, 0, 0, 8'h00);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 3'd1, 1, 0, 16'hA008, 8'h00, 1, 0, 0, 8'h00);
    tbl[10] = mk(0, 1, 1, 16'h1234, 8'h5A, 8'h00, 3'd2, 0, 0, 16'h1234, 8'h5A, 1, 1, 0, 8'h00);
    tbl[11] = mk(0, 1, 1, 16'h1234, 8'h5A, 8'h00, 3'd3, 0, 0, 16'h1234, 8'h5A, 0, 1, 0, 8'h00);
    tbl[12] = mk(0, 1, 1, 16'h1234, 8'h5A, 8'h00, 3'd4, 1, 1, 16'hA00C, 8'h5A, 1, 0, 1, 8'h00);
    tbl[13] = mk(0, 1, 0, 16'h8000, 8'h5A, 8'h00, 3'd5, 1, 1, 16'hA00C, 8'h5A, 1, 0, 0, 8'h00);
    tbl[14] = mk(0, 1, 0, 16'h8000, 8'h5A, 8'h00, 3'd6, 0, 1, 16'h8000, 8'h5A, 1, 0, 0, 8'h00);
    tbl[15] = mk(0, 1, 0, 16'h8000, 8'h5A, 8'h11, 3'd7, 0, 1, 16'h8000, 8'h5A, 1, 0, 0, 8'h00);
    tbl[16] = mk(0, 1, 0, 16'h8000, 8'h5A, 8'hC3, 3'd0, 1, 0, 16'hA010, 8'h5A, 1, 0, 1, 8'hC3);
    tbl[17] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd1, 1, 0, 16'hA010, 8'h5A, 1, 0, 0, 8'hC3);
    tbl[18] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd2, 0, 0, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[19] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd3, 0, 0, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[20] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd4, 0, 1, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[21] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd5, 0, 1, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[22] = mk(1, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd6, 0, 1, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[23] = mk(0, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd7, 0, 1, 16'hA010, 8'h5A, 1, 1, 0, 8'hC3);
    tbl[24] = mk(0, 0, 0, 16'h8000, 8'h5A, 8'hEE, 3'd0, 1, 0, 16'hA018, 8'h5A, 1, 0, 0, 8'hC3);

    reset = 1; retrace = 0; vid_addr = 16'h0; SRAM_DQ = 8'h0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    aux_req = 0; aux_we = 0; aux_addr = 16'h0; aux_wdata = 8'h0;
    @(negedge clk24);
    repeat (3) step();
    chk("reset_vals",
        64'({phase, video_slice, pipe_ab, cpu_ack, aux_ack, cpu_rdata, aux_rdata,
             SRAM_ADDR, SRAM_WDATA, SRAM_WE_N, SRAM_OE_N}),
        64'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b1, 1'b1}));

    // Cycle table: row inputs are applied one cycle before the edge that
    // produces the row's expected outputs.
    for (int i = 0; i < 25; i++) begin
      reset     = 0;
      retrace   = tbl[i].rt;
      cpu_req   = tbl[i].rq;
      cpu_we    = tbl[i].we;
      cpu_addr  = tbl[i].a;
      cpu_wdata = tbl[i].wd;
      SRAM_DQ   = tbl[i].dq;
      vid_addr  = 16'hA000 + 16'(i);
      step();
      chk($sformatf("row%0d", i),
          64'({phase, video_slice, pipe_ab, SRAM_ADDR, SRAM_WDATA, SRAM_WE_N,
               SRAM_OE_N, cpu_ack, cpu_rdata, aux_ack}),
          64'({tbl[i].ph, tbl[i].vs, tbl[i].pab, tbl[i].sa, tbl[i].swd, tbl[i].wen,
               tbl[i].oen, tbl[i].ack, tbl[i].rd, 1'b0}));
    end

    // Reset during the data phase of a CPU write
    wait_phase(3'd1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0BEE; cpu_wdata = 8'h77;
    step();
    chk("rst_grant", 64'({phase, SRAM_ADDR, SRAM_WDATA, SRAM_OE_N}),
        64'({3'd2, 16'h0BEE, 8'h77, 1'b1}));
    step();
    chk("rst_we_low", 64'({phase, SRAM_WE_N}), 64'({3'd3, 1'b0}));
    reset = 1; cpu_req = 0;
    step();
    chk("rst_abort", 64'({phase, SRAM_WE_N, SRAM_OE_N, cpu_ack, SRAM_ADDR}),
        64'({3'd0, 1'b1, 1'b1, 1'b0, 16'h0000}));
    reset = 0; acks = 0;
    repeat (8) begin step(); acks += int'(cpu_ack); end
    chk("rst_no_ack", 64'(acks), 64'd0);

`ifdef SRAM_ARB_AUX_EN
    // CPU and aux both saturating: four CPU grants, then one aux grant
    cpu_req = 1; cpu_we = 0; aux_req = 1; aux_we = 0; aux_addr = 16'h4444;
    retrace = 0; n = 0; both = 0; seq = '0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      step();
      if (cpu_ack && aux_ack) both++;
      if (cpu_ack || aux_ack) begin
        seq[n] = aux_ack;
        n++;
      end
    end
    chk("starve_n", 64'(n), 64'd10);
    chk("starve_seq", 64'(seq), 64'(10'b1000010000));
    chk("ack_excl", 64'(both), 64'd0);
    cpu_req = 0; aux_req = 0;
    repeat (8) step();

    // Retrace, aux only: every slot goes to aux
    retrace = 1; aux_req = 1; SRAM_DQ = 8'h3C; cnt = 0; bad = 0;
    repeat (4) step();
    repeat (16) begin
      step();
      cnt += int'(aux_ack);
      bad += int'(video_slice);
    end
    chk("retrace_aux_acks", 64'(cnt), 64'd8);
    chk("retrace_no_video", 64'(bad), 64'd0);
    chk("retrace_aux_rdata", 64'(aux_rdata), 64'h3C);
`else
    // CPU always wins the requester slots even with aux pending
    cpu_req = 1; cpu_we = 0; aux_req = 1; retrace = 0; cnt = 0;
    repeat (8) step();
    repeat (32) begin step(); cnt += int'(cpu_ack); end
    chk("cpu_all_slots", 64'(cnt), 64'd8);
    cpu_req = 0;
    repeat (8) step();

    // Retrace with aux requesting: slots stay idle, aux never acks
    retrace = 1; aux_req = 1; SRAM_DQ = 8'h3C; cnt = 0; bad = 0; acks = 0;
    repeat (4) step();
    repeat (16) begin
      step();
      cnt  += int'(aux_ack);
      bad  += int'(aux_rdata != 8'h00);
      acks += int'(!SRAM_OE_N);
    end
    chk("noaux_ack", 64'(cnt), 64'd0);
    chk("noaux_rdata", 64'(bad), 64'd0);
    chk("noaux_idle_oe", 64'(acks), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
